// File: rtl/alu_ctrl_if.sv
// Request/response channel between a client and the alu_ctrl sequencer.
// The slave side is the controller; the master side issues ops and takes results.
interface alu_ctrl_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_lo;
    logic [N-1:0] rsp_hi;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
    );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencer in front of the registered ALU: issues one op, collects z one edge
// later, and for MUL/DIV follows up with MFHI to fetch the high word/remainder.
//
// state | meaning
// IDLE  | req_ready raised one edge after reset, waiting for a request
// ERR   | illegal op or divide-by-zero latched, raise rsp_valid next edge
// EXEC  | ALU samples the op; queue MFHI for MUL/DIV
// LO    | capture z as the primary result
// HI    | capture z from the MFHI as the high word
// RESP  | hold the response until rsp_ready
module alu_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_ctrl_if.slave    bus,
    output logic [N-1:0] alu_x,
    output logic [N-1:0] alu_y,
    output logic [3:0]   alu_mode,
    input  logic [N-1:0] alu_z
);
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_RSVD = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;

    typedef enum logic [2:0] {IDLE, ERR, EXEC, LO, HI, RESP} state_t;

    state_t       state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic         req_ready_q, req_ready_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_lo_q, rsp_lo_d;
    logic [N-1:0] rsp_hi_q, rsp_hi_d;
    logic         rsp_err_q, rsp_err_d;
    logic [N-1:0] alu_x_q, alu_x_d;
    logic [N-1:0] alu_y_q, alu_y_d;
    logic [3:0]   alu_mode_q, alu_mode_d;
    logic         long_op;

    assign long_op = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_err_d   = rsp_err_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        alu_mode_d  = OP_NOP;
        case (state_q)
            IDLE: begin
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                end else if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    op_d        = bus.req_op;
                    if (bus.req_op == OP_NOP || bus.req_op == OP_RSVD) begin
                        rsp_lo_d  = '0;
                        rsp_hi_d  = '0;
                        rsp_err_d = 1'b1;
                        state_d   = ERR;
                    end else if (bus.req_op == OP_DIV && bus.req_b == '0) begin
                        // ALU is left alone so its hi register survives
                        rsp_lo_d  = '1;
                        rsp_hi_d  = bus.req_a;
                        rsp_err_d = 1'b1;
                        state_d   = ERR;
                    end else begin
                        alu_x_d    = bus.req_a;
                        alu_y_d    = bus.req_b;
                        alu_mode_d = bus.req_op;
                        state_d    = EXEC;
                    end
                end
            end
            ERR: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            EXEC: begin
                if (long_op) alu_mode_d = OP_MFHI;
                state_d = LO;
            end
            LO: begin
                rsp_lo_d = alu_z;
                if (long_op) begin
                    state_d = HI;
                end else begin
                    rsp_hi_d    = '0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            HI: begin
                rsp_hi_d    = alu_z;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_err_q   <= 1'b0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_mode_q  <= OP_NOP;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_err_q   <= rsp_err_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_mode_q  <= alu_mode_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_x         = alu_x_q;
    assign alu_y         = alu_y_q;
    assign alu_mode      = alu_mode_q;
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing front end for the team's registered N-bit ALU (mode-encoded ops: 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV, 0101 AND, 0110 OR, 0111 XOR, 1000 NOR, 1001 SLL, 1010 SLR, 1011 SLT, 1101 MFHI, 1110 EQ, 1111 NEQ). Accepts one operation at a time over a valid/ready request channel and drives the ALU's x/y/mode inputs. It collects the ALU result one edge later and, for MUL/DIV, issues an automatic MFHI to fetch the high half or remainder. Returns {lo, hi, err} over a valid/ready response channel.

## Interface
- N, 32, datapath width; must match the ALU instance
- clk  in  1  rising-edge clock; shared with the ALU
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle and able to accept
- req_op  in  4  ALU mode code
- req_a  in  N  operand x
- req_b  in  N  operand y
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_lo  out  N  primary result (z)
- rsp_hi  out  N  MUL high word / DIV remainder; 0 for all other ops
- rsp_err  out  1  illegal op or divide-by-zero
- alu_x  out  N  to ALU x
- alu_y  out  N  to ALU y
- alu_mode  out  4  to ALU mode; 0000 when idle (ALU holds z)
- alu_z  in  N  from ALU z

## Operation
- All outputs are registered. Reset values: req_ready=0, rsp_valid=0, rsp_lo=0, rsp_hi=0, rsp_err=0, alu_x=0, alu_y=0, alu_mode=0000. State is IDLE.
- First edge after rst_n rises: req_ready←1.
- **IDLE** (req_ready=1). An accept occurs on an edge with req_valid&req_ready. At the accept edge, req_ready←0 and:
  - Illegal op (0000, 1100): go to RESP with err=1, lo=0, hi=0. ALU not touched.
  - DIV with req_b==0: go to RESP with err=1, lo={N{1}}, hi=req_a. ALU not touched, so ALU hi is preserved.
  - Otherwise: alu_x←a, alu_y←b, alu_mode←op. Go to EXEC.
- **EXEC**: the ALU samples the operation at this edge. alu_mode←1101 if op is MUL or DIV, else 0000. Go to LO.
- **LO**: rsp_lo←alu_z.
  - MUL/DIV: alu_mode←0000, go to HI. The ALU performs MFHI at this same edge.
  - Other ops: rsp_hi←0, rsp_err←0, rsp_valid←1, go to RESP.
- **HI**: rsp_hi←alu_z, rsp_err←0, rsp_valid←1, go to RESP.
- **RESP**: rsp_* held stable while rsp_valid&!rsp_ready. At the handshake edge: rsp_valid←0, req_ready←1, go to IDLE. rsp_lo/hi/err keep their last values.
- A direct MFHI request (1101) is a normal single op. It returns the ALU's current hi, with rsp_hi=0.
- No arithmetic is done in this block. Shifts pass the full-width b. Overflow is ignored, as in the ALU.
- Reset mid-operation: the transaction is dropped with no response, and all outputs return to their reset values. The ALU's hi and z are not reset and are undefined to the next user.

## Timing
- Accept at edge E0.
- Simple op: rsp_valid high after E2, so a response handshake is possible at E3 at the earliest.
- MUL/DIV: rsp_valid high after E3. The ALU sees op in cycle E0–E1 and 1101 in cycle E1–E2.
- Error paths: rsp_valid high after E1.
- Throughput: one op per 4 cycles (simple op, rsp_ready held 1).
- req_valid is ignored whenever req_ready=0. No request queuing.
- alu_mode is 0000 in every cycle the controller is not issuing, so z is stable for external observers.

## Test plan
- ADD a=7, b=5, rsp_ready=1 → alu_mode=0001 for exactly one cycle; rsp_valid after E2 with lo=12, hi=0, err=0; req_ready back to 1 after E3.
- MUL a=0x0001_0000, b=0x0001_0000 → alu_mode sequence 0011, 1101, 0000; rsp_valid after E3 with lo=0, hi=1.
- DIV 100/7 → lo=14, hi=2. Then DIV 5/0 → err=1, lo=0xFFFF_FFFF, hi=5, rsp_valid after E1, alu_mode stays 0000. A following MFHI request returns lo=2.
- Illegal op 1100 → err=1, lo=0, hi=0 after E1; no ALU activity.
- Backpressure: SUB 3−5 with rsp_ready=0 for 6 cycles → lo=0xFFFF_FFFE held stable, req_ready=0, a pulsed req_valid during that time is not accepted; completes one edge after rsp_ready=1.
- rst_n pulsed low in the HI state of a MUL → all outputs immediately at reset values, no rsp_valid; req_ready=1 one edge after release; a subsequent ADD 1+1 returns lo=2.
